acc_segment_sequencer: RTL and testbench
========================================

// Module: acc_segment_sequencer
// PURPOSE
//  Upstream feeder for the acceleration profile generator. Buffers motion segments
//  (x/v/a/j/jj/target_v values, set flags, duration) and issues the generator's
//  load/set_* strobes at segment boundaries. Produces the periodic acc_step tick and
//  counts acc_steps per segment. Drives abort and waits for the generator to report stopped.
// PARAMETERS
//  DIV_W      16  width of acc_div (clocks per acc_step = acc_div+1)
//  DUR_W      32  width of segment duration (acc_steps)
//  FIFO_DEPTH 4   segment FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  acc_div    in   DIV_W  tick divider, must be >=1; sampled on IDLE->LOAD
//  enable     in   1   allow leaving IDLE
//  seg_valid  in   1   segment offered
//  seg_ready  out  1   FIFO not full
//  seg_flags  in   6   {set_target_v,set_jj,set_j,set_a,set_v,set_x}
//  seg_x      in   64  signed x value
//  seg_v/seg_a/seg_j/seg_jj/seg_target_v  in  32 each, signed
//  seg_dur    in   DUR_W  acc_steps to run this segment (0 = parameter-only)
//  abort_req  in   1   abort pulse
//  gen_stopped in  1   generator 'stopped' output
//  acc_step   out  1   one-clock tick to generator
//  load       out  1   one-clock load strobe; set_x..set_target_v out 1 each (valid with load)
//  x_val 64 / v_val,a_val,j_val,jj_val,target_v_val 32  out  values, valid with load
//  abort      out  1   level, held high in ABORTING
//  busy       out  1   state != IDLE
//  seg_done   out  1   pulse on cycle after a segment's last acc_step
//  underrun   out  1   sticky: RUN ended with FIFO empty; cleared by reset or next LOAD
// BEHAVIOUR
//  Reset: all outputs 0, seg_ready 1, FIFO emptied, state IDLE; mid-operation reset drops all.
//  FIFO push when seg_valid&&seg_ready; pop only in LOAD. Push+pop same cycle allowed when full.
//  Tick counter: loaded with acc_div on IDLE->LOAD; free-runs down in LOAD/RUN/ABORTING;
//   tick at 0, reload acc_div. Period constant across segment boundaries.
//  acc_step never coincides with load: tick landing on LOAD cycle is held pending, emitted
//   in following cycle.
//  FSM: IDLE -> LOAD when enable && FIFO non-empty.
//   LOAD (1 clk): load=1, set_*/values from FIFO head, pop, dur_cnt<=seg_dur;
//    -> RUN if seg_dur!=0; else seg_done, -> LOAD if FIFO non-empty else IDLE (no underrun).
//   RUN: each acc_step decrements dur_cnt; after step with dur_cnt==1 -> seg_done next clk;
//    -> LOAD if FIFO non-empty, else underrun=1, -> IDLE (generator keeps its last a/v).
//   Any state but IDLE: abort_req -> ABORTING (priority over LOAD/segment end); FIFO flushed.
//   ABORTING: abort=1, ticks continue; -> IDLE when gen_stopped=1 sampled after >=1 acc_step.
//   IDLE + abort_req: ignored. seg_ready=0 in ABORTING.
//  dur_cnt DUR_W unsigned, no wrap (stops at 0). Outputs registered; load and values same clk.
// CONFIGURATION
//  ACC_SEQ_SEG_COUNT_EN defined: extra out seg_count[15:0], +1 per seg_done, wraps 0xFFFF->0,
//   reset 0. Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  acc_seq_pkg: flag bit indices, FSM state encoding, segment record width/field offsets.
//  Sub-module seg_fifo: synchronous FIFO (width=segment record, depth FIFO_DEPTH), full/empty.
// TESTING
//  acc_div=3, one seg dur=5 a=10 -> load@LOAD, 5 acc_step 4 clk apart, seg_done, underrun=1, IDLE.
//  Two segs dur=2,3 queued -> steps evenly 4 clk apart across boundary, 2nd load between, no underrun.
//  Seg dur=0 then dur=2 -> two loads on consecutive clks, 2 acc_steps, one seg_done per seg.
//  FIFO fill 4 with enable=0 -> seg_ready=0; 5th held; enable=1 -> pops in order, flags match.
//  abort_req mid-RUN, gen_stopped after 3 ticks -> abort high till then, FIFO empty, IDLE.
//  reset during RUN -> next clk all outputs 0, busy 0, seg_ready 1.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// Shared definitions for the acceleration segment sequencer:
// flag bit positions, FSM encoding and segment record layout.
package acc_seq_pkg;

    localparam int FLG_X  = 0;
    localparam int FLG_V  = 1;
    localparam int FLG_A  = 2;
    localparam int FLG_J  = 3;
    localparam int FLG_JJ = 4;
    localparam int FLG_TV = 5;
    localparam int NFLG   = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_ABORT = 2'd3
    } state_e;

    // Record: {dur, target_v, jj, j, a, v, x, flags}, flags in the LSBs
    localparam int REC_FLG = 0;
    localparam int REC_X   = 6;
    localparam int REC_V   = 70;
    localparam int REC_A   = 102;
    localparam int REC_J   = 134;
    localparam int REC_JJ  = 166;
    localparam int REC_TV  = 198;
    localparam int REC_DUR = 230;

    function automatic int rec_width(input int dur_w);
        return REC_DUR + dur_w;
    endfunction

endpackage

// File: rtl/acc_segment_sequencer_seg_fifo.sv
// Synchronous segment FIFO with flush; simultaneous push and pop
// are accepted while full.
module seg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         multi
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign multi   = (cnt_q > (AW+1)'(1));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wp_q] <= wdata;
        end
    end

    always_comb begin
        wp_d  = do_push ? wp_q + AW'(1) : wp_q;
        rp_d  = do_pop ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acc_segment_sequencer.sv
// Segment feeder for the acceleration profile generator.
// Optional ACC_SEQ_SEG_COUNT_EN adds a wrapping seg_count output.
module acc_segment_sequencer
    import acc_seq_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int DUR_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] acc_div,
    input  logic             enable,
    input  logic             seg_valid,
    output logic             seg_ready,
    input  logic [NFLG-1:0]  seg_flags,
    input  logic [63:0]      seg_x,
    input  logic [31:0]      seg_v,
    input  logic [31:0]      seg_a,
    input  logic [31:0]      seg_j,
    input  logic [31:0]      seg_jj,
    input  logic [31:0]      seg_target_v,
    input  logic [DUR_W-1:0] seg_dur,
    input  logic             abort_req,
    input  logic             gen_stopped,
    output logic             acc_step,
    output logic             load,
    output logic             set_x,
    output logic             set_v,
    output logic             set_a,
    output logic             set_j,
    output logic             set_jj,
    output logic             set_target_v,
    output logic [63:0]      x_val,
    output logic [31:0]      v_val,
    output logic [31:0]      a_val,
    output logic [31:0]      j_val,
    output logic [31:0]      jj_val,
    output logic [31:0]      target_v_val,
    output logic             abort,
    output logic             busy,
    output logic             seg_done,
`ifdef ACC_SEQ_SEG_COUNT_EN
    output logic [15:0]      seg_count,
`endif
    output logic             underrun
);

    localparam int REC_W = rec_width(DUR_W);

    state_e state_q, state_d;

    logic [DIV_W-1:0] tick_q, tick_d, div_q, div_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             pend_q, pend_d;
    logic             seen_q, seen_d;
    logic             donep_q, donep_d;
    logic             step_q, step_d;
    logic             load_q, load_d;
    logic [NFLG-1:0]  flags_q, flags_d;
    logic [63:0]      x_q, x_d;
    logic [31:0]      v_q, v_d, a_q, a_d, j_q, j_d;
    logic [31:0]      jj_q, jj_d, tv_q, tv_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             under_q, under_d;

    logic [REC_W-1:0] wdata, head;
    logic [DUR_W-1:0] h_dur;
    logic             f_full, f_empty, f_multi;
    logic             push, is_load, running;
    logic             tick_now, want, emit, last, abort_go;

    assign wdata = {seg_dur, seg_target_v, seg_jj, seg_j,
                    seg_a, seg_v, seg_x, seg_flags};
    assign h_dur = head[REC_DUR +: DUR_W];

    assign is_load   = (state_q == S_LOAD);
    assign running   = (state_q != S_IDLE);
    assign seg_ready = (!f_full || is_load) && (state_q != S_ABORT);
    assign push      = seg_valid && seg_ready;
    assign abort_go  = running && abort_req && (state_q != S_ABORT);

    // A tick falling on a LOAD cycle waits until the load has gone out
    assign tick_now = running && (tick_q == '0);
    assign want     = tick_now || pend_q;
    assign emit     = want && running && !is_load;
    assign last     = (state_q == S_RUN) && emit
                   && (dur_q == DUR_W'(1));

    seg_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (is_load),
        .flush (abort_go),
        .wdata (wdata),
        .rdata (head),
        .full  (f_full),
        .empty (f_empty),
        .multi (f_multi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable && !f_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort_go)           state_d = S_ABORT;
                else if (h_dur != '0)   state_d = S_RUN;
                else if (f_multi)       state_d = S_LOAD;
                else                    state_d = S_IDLE;
            end
            S_RUN: begin
                if (abort_go)           state_d = S_ABORT;
                else if (last)          state_d = f_empty ? S_IDLE : S_LOAD;
            end
            S_ABORT: begin
                if (gen_stopped && seen_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tick_d  = tick_q;
        div_d   = div_q;
        pend_d  = 1'b0;
        dur_d   = dur_q;
        seen_d  = seen_q;
        donep_d = 1'b0;
        under_d = under_q;
        step_d  = emit;
        load_d  = is_load;
        flags_d = '0;
        x_d     = x_q;
        v_d     = v_q;
        a_d     = a_q;
        j_d     = j_q;
        jj_d    = jj_q;
        tv_d    = tv_q;
        if (!running) begin
            if (state_d == S_LOAD) begin
                tick_d = acc_div;
                div_d  = acc_div;
            end
        end else begin
            tick_d = tick_now ? div_q : tick_q - DIV_W'(1);
            pend_d = want && is_load;
        end
        if (is_load) begin
            flags_d = head[REC_FLG +: NFLG];
            x_d     = head[REC_X +: 64];
            v_d     = head[REC_V +: 32];
            a_d     = head[REC_A +: 32];
            j_d     = head[REC_J +: 32];
            jj_d    = head[REC_JJ +: 32];
            tv_d    = head[REC_TV +: 32];
            dur_d   = h_dur;
            under_d = 1'b0;
            donep_d = (h_dur == '0) && !abort_go;
        end
        if ((state_q == S_RUN) && emit && (dur_q != '0)) begin
            dur_d = dur_q - DUR_W'(1);
        end
        if (last && !abort_go) begin
            donep_d = 1'b1;
            if (f_empty) under_d = 1'b1;
        end
        if ((state_d == S_ABORT) && (state_q != S_ABORT)) begin
            seen_d = 1'b0;
        end else if ((state_q == S_ABORT) && emit) begin
            seen_d = 1'b1;
        end
        abort_d = (state_d == S_ABORT);
        busy_d  = (state_d != S_IDLE);
        done_d  = donep_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= '0;
            div_q   <= '0;
            dur_q   <= '0;
            pend_q  <= 1'b0;
            seen_q  <= 1'b0;
            donep_q <= 1'b0;
            step_q  <= 1'b0;
            load_q  <= 1'b0;
            flags_q <= '0;
            x_q     <= '0;
            v_q     <= '0;
            a_q     <= '0;
            j_q     <= '0;
            jj_q    <= '0;
            tv_q    <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            div_q   <= div_d;
            dur_q   <= dur_d;
            pend_q  <= pend_d;
            seen_q  <= seen_d;
            donep_q <= donep_d;
            step_q  <= step_d;
            load_q  <= load_d;
            flags_q <= flags_d;
            x_q     <= x_d;
            v_q     <= v_d;
            a_q     <= a_d;
            j_q     <= j_d;
            jj_q    <= jj_d;
            tv_q    <= tv_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            under_q <= under_d;
        end
    end

`ifdef ACC_SEQ_SEG_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d     = donep_q ? cnt_q + 16'd1 : cnt_q;
    assign seg_count = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    assign acc_step     = step_q;
    assign load         = load_q;
    assign set_x        = flags_q[FLG_X];
    assign set_v        = flags_q[FLG_V];
    assign set_a        = flags_q[FLG_A];
    assign set_j        = flags_q[FLG_J];
    assign set_jj       = flags_q[FLG_JJ];
    assign set_target_v = flags_q[FLG_TV];
    assign x_val        = x_q;
    assign v_val        = v_q;
    assign a_val        = a_q;
    assign j_val        = j_q;
    assign jj_val       = jj_q;
    assign target_v_val = tv_q;
    assign abort        = abort_q;
    assign busy         = busy_q;
    assign seg_done     = done_q;
    assign underrun     = under_q;

endmodule

// File: tb/tb_acc_segment_sequencer.sv
// Directed bench for acc_segment_sequencer: segment timing, tick
// holding, FIFO ordering, abort and reset behaviour.
module tb_acc_segment_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, seg_valid, abort_req, gen_stopped;
    logic [15:0] acc_div;
    logic [5:0]  seg_flags;
    logic [63:0] seg_x;
    logic [31:0] seg_v, seg_a, seg_j, seg_jj, seg_target_v, seg_dur;
    logic        seg_ready, acc_step, load, abort, busy, seg_done, underrun;
    logic        set_x, set_v, set_a, set_j, set_jj, set_target_v;
    logic [63:0] x_val;
    logic [31:0] v_val, a_val, j_val, jj_val, target_v_val;
`ifdef ACC_SEQ_SEG_COUNT_EN
    logic [15:0] seg_count;
`endif

    wire [5:0]   fl_vec = {set_target_v, set_jj, set_j, set_a, set_v, set_x};
    wire [235:0] outv   = {acc_step, load, fl_vec, x_val, v_val, a_val, j_val,
                           jj_val, target_v_val, abort, busy, seg_done, underrun};

    int n_run = 0;
    int n_fail = 0;
    int kk, under_k, n_coinc;
    int load_k[$], load_fl[$], load_x[$], step_k[$], done_k[$];

    always #5 clk = ~clk;

    acc_segment_sequencer dut (
        .clk(clk), .reset(reset), .acc_div(acc_div), .enable(enable),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_flags(seg_flags),
        .seg_x(seg_x), .seg_v(seg_v), .seg_a(seg_a), .seg_j(seg_j),
        .seg_jj(seg_jj), .seg_target_v(seg_target_v), .seg_dur(seg_dur),
        .abort_req(abort_req), .gen_stopped(gen_stopped),
        .acc_step(acc_step), .load(load), .set_x(set_x), .set_v(set_v),
        .set_a(set_a), .set_j(set_j), .set_jj(set_jj),
        .set_target_v(set_target_v), .x_val(x_val), .v_val(v_val),
        .a_val(a_val), .j_val(j_val), .jj_val(jj_val),
        .target_v_val(target_v_val), .abort(abort), .busy(busy),
        .seg_done(seg_done),
`ifdef ACC_SEQ_SEG_COUNT_EN
        .seg_count(seg_count),
`endif
        .underrun(underrun)
    );

    function automatic string q2s(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, (i == 0) ? "" : ",", $sformatf("%0d", q[i])};
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        reset = 1'b1; enable = 1'b0; seg_valid = 1'b0;
        abort_req = 1'b0; gen_stopped = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic push_seg(input logic [5:0] f, input logic [63:0] x,
                            input logic [31:0] a, input logic [31:0] d);
        seg_valid = 1'b1; seg_flags = f; seg_x = x; seg_a = a;
        seg_v = a + 1; seg_j = a + 2; seg_jj = a + 3; seg_target_v = a + 4;
        seg_dur = d;
        cyc();
        seg_valid = 1'b0;
    endtask

    task automatic clr();
        kk = 0; under_k = -1; n_coinc = 0;
        load_k.delete(); load_fl.delete(); load_x.delete();
        step_k.delete(); done_k.delete();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            kk++;
            if (load) begin
                load_k.push_back(kk);
                load_fl.push_back(int'(fl_vec));
                load_x.push_back(int'(x_val[31:0]));
            end
            if (acc_step) step_k.push_back(kk);
            if (seg_done) done_k.push_back(kk);
            if (underrun && under_k < 0) under_k = kk;
            if (load && acc_step) n_coinc++;
        end
    endtask

    task automatic test_reset();
        rst();
        n_run++;
        if (outv !== '0) begin
            n_fail++; $display("FAIL reset_outs: got %h, expected 0", outv);
        end
        n_run++;
        if (seg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, expected 1", seg_ready);
        end
    endtask

    task automatic test_single_seg();
        rst(); acc_div = 16'd3;
        push_seg(6'b000100, 64'd0, 32'd10, 32'd5);
        enable = 1'b1; clr(); run_cycles(30); enable = 1'b0;
        n_run++;
        if (q2s(load_k) != "2") begin
            n_fail++; $display("FAIL single_load: got %s, expected 2", q2s(load_k));
        end
        n_run++;
        if (q2s(load_fl) != "4") begin
            n_fail++; $display("FAIL single_flags: got %s, expected 4", q2s(load_fl));
        end
        n_run++;
        if (q2s(step_k) != "5,9,13,17,21") begin
            n_fail++;
            $display("FAIL single_steps: got %s, expected 5,9,13,17,21", q2s(step_k));
        end
        n_run++;
        if (q2s(done_k) != "22") begin
            n_fail++; $display("FAIL single_done: got %s, expected 22", q2s(done_k));
        end
        n_run++;
        if (under_k != 21) begin
            n_fail++; $display("FAIL single_underrun: got %0d, expected 21", under_k);
        end
        n_run++;
        if (busy !== 1'b0 || a_val !== 32'd10) begin
            n_fail++;
            $display("FAIL single_end: got busy=%b a=%0d, expected busy=0 a=10", busy, a_val);
        end
    endtask

    task automatic test_two_segs();
        rst(); acc_div = 16'd3;
        push_seg(6'b000100, 64'd0, 32'd5, 32'd2);
        push_seg(6'b100100, 64'd0, 32'hFFFF_FFFD, 32'd3);
        enable = 1'b1; clr(); run_cycles(30); enable = 1'b0;
        n_run++;
        if (q2s(load_k) != "2,10" || q2s(load_fl) != "4,36") begin
            n_fail++;
            $display("FAIL two_loads: got %s/%s, expected 2,10/4,36", q2s(load_k), q2s(load_fl));
        end
        n_run++;
        if (q2s(step_k) != "5,9,13,17,21") begin
            n_fail++;
            $display("FAIL two_steps: got %s, expected 5,9,13,17,21", q2s(step_k));
        end
        n_run++;
        if (q2s(done_k) != "10,22" || under_k != 21) begin
            n_fail++;
            $display("FAIL two_done: got %s u=%0d, expected 10,22 u=21", q2s(done_k), under_k);
        end
        n_run++;
        if (a_val !== 32'hFFFF_FFFD || target_v_val !== 32'd1) begin
            n_fail++;
            $display("FAIL two_vals: got a=%h tv=%h, expected fffffffd/1", a_val, target_v_val);
        end
    endtask

    task automatic test_param_then_run();
        rst(); acc_div = 16'd3;
        push_seg(6'b000001, 64'h1_0000_0005, 32'd0, 32'd0);
        push_seg(6'b000100, 64'd0, 32'd7, 32'd2);
        enable = 1'b1; clr(); run_cycles(16); enable = 1'b0;
        n_run++;
        if (q2s(load_k) != "2,3" || q2s(load_fl) != "1,4" || q2s(load_x) != "5,0") begin
            n_fail++;
            $display("FAIL par_loads: got %s/%s/%s, expected 2,3/1,4/5,0",
                     q2s(load_k), q2s(load_fl), q2s(load_x));
        end
        n_run++;
        if (q2s(step_k) != "5,9") begin
            n_fail++; $display("FAIL par_steps: got %s, expected 5,9", q2s(step_k));
        end
        n_run++;
        if (q2s(done_k) != "3,10" || under_k != 9) begin
            n_fail++;
            $display("FAIL par_done: got %s u=%0d, expected 3,10 u=9", q2s(done_k), under_k);
        end
`ifdef ACC_SEQ_SEG_COUNT_EN
        n_run++;
        if (seg_count !== 16'd2) begin
            n_fail++; $display("FAIL par_count: got %0d, expected 2", seg_count);
        end
`endif
    endtask

    task automatic test_pending_hold();
        rst(); acc_div = 16'd1;
        push_seg(6'b000001, 64'd0, 32'd0, 32'd0);
        push_seg(6'b000100, 64'd0, 32'd9, 32'd1);
        enable = 1'b1; clr(); run_cycles(12); enable = 1'b0;
        n_run++;
        if (q2s(load_k) != "2,3" || q2s(step_k) != "4" || n_coinc != 0) begin
            n_fail++;
            $display("FAIL hold_step: got loads %s steps %s coinc %0d, expected 2,3 / 4 / 0",
                     q2s(load_k), q2s(step_k), n_coinc);
        end
        n_run++;
        if (q2s(done_k) != "3,5" || under_k != 4) begin
            n_fail++;
            $display("FAIL hold_done: got %s u=%0d, expected 3,5 u=4", q2s(done_k), under_k);
        end
    endtask

    task automatic test_fifo_fill();
        bit rdy_seen = 1'b0;
        rst(); acc_div = 16'd3;
        for (int i = 0; i < 4; i++) begin
            push_seg(6'(1 << i), 64'(100 + i), 32'd0, 32'd0);
        end
        n_run++;
        if (seg_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got ready=%b, expected 0", seg_ready);
        end
        seg_valid = 1'b1; seg_flags = 6'b100000; seg_x = 64'd200;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (seg_ready || busy) rdy_seen = 1'b1;
        end
        seg_valid = 1'b0;
        n_run++;
        if (rdy_seen) begin
            n_fail++; $display("FAIL fill_hold: got ready/busy high, expected both 0");
        end
        enable = 1'b1; clr(); run_cycles(12); enable = 1'b0;
        n_run++;
        if (q2s(load_k) != "2,3,4,5" || q2s(load_fl) != "1,2,4,8") begin
            n_fail++;
            $display("FAIL fill_order: got %s/%s, expected 2,3,4,5/1,2,4,8",
                     q2s(load_k), q2s(load_fl));
        end
        n_run++;
        if (q2s(load_x) != "100,101,102,103") begin
            n_fail++;
            $display("FAIL fill_x: got %s, expected 100,101,102,103", q2s(load_x));
        end
        n_run++;
        if (q2s(done_k) != "3,4,5,6" || step_k.size() != 0 || under_k != -1) begin
            n_fail++;
            $display("FAIL fill_done: got %s steps %s u=%0d, expected 3,4,5,6 / none / -1",
                     q2s(done_k), q2s(step_k), under_k);
        end
        n_run++;
        if (seg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_end: got ready=%b busy=%b, expected 1/0", seg_ready, busy);
        end
    endtask

    task automatic test_abort();
        int nst = 0;
        int it = -1;
        bit drop = 1'b0;
        rst(); acc_div = 16'd3;
        push_seg(6'b000100, 64'd0, 32'd1, 32'd20);
        push_seg(6'b000100, 64'd0, 32'd2, 32'd20);
        enable = 1'b1; clr(); run_cycles(10);
        abort_req = 1'b1; cyc(); abort_req = 1'b0;
        n_run++;
        if (abort !== 1'b1 || seg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_enter: got abort=%b ready=%b, expected 1/0", abort, seg_ready);
        end
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (abort !== 1'b1) drop = 1'b1;
            if (acc_step) nst++;
            if (nst == 3) begin
                it = i;
                break;
            end
        end
        n_run++;
        if (it != 9 || drop) begin
            n_fail++;
            $display("FAIL abort_ticks: got 3rd step at %0d drop=%b, expected 9/0", it, drop);
        end
        gen_stopped = 1'b1; cyc(); gen_stopped = 1'b0;
        n_run++;
        if (abort !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_exit: got abort=%b busy=%b, expected 0/0", abort, busy);
        end
        clr(); run_cycles(8); enable = 1'b0;
        n_run++;
        if (load_k.size() != 0 || busy !== 1'b0 || seg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_flush: got loads %s busy=%b ready=%b, expected none/0/1",
                     q2s(load_k), busy, seg_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        rst(); acc_div = 16'd3;
        push_seg(6'b111111, 64'd55, 32'd77, 32'd20);
        push_seg(6'b000100, 64'd0, 32'd3, 32'd20);
        enable = 1'b1; clr(); run_cycles(8);
        reset = 1'b1; cyc();
        n_run++;
        if (outv !== '0 || seg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_outs: got %h ready=%b, expected 0/1", outv, seg_ready);
        end
        reset = 1'b0; clr(); run_cycles(6); enable = 1'b0;
        n_run++;
        if (load_k.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flush: got loads %s busy=%b, expected none/0",
                     q2s(load_k), busy);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; seg_valid = 1'b0; abort_req = 1'b0;
        gen_stopped = 1'b0; acc_div = 16'd3; seg_flags = '0; seg_x = '0;
        seg_v = '0; seg_a = '0; seg_j = '0; seg_jj = '0; seg_target_v = '0;
        seg_dur = '0;
        test_reset();
        test_single_seg();
        test_two_segs();
        test_param_then_run();
        test_pending_hold();
        test_fifo_fill();
        test_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
